// File: rtl/interp_i2s_tx.sv
// rtl/interp_i2s_tx.sv - 96 kHz stereo I2S transmitter fed by the interpolator output strobe
//
// Scales 34-bit signed interpolator sums to 24 bits with saturation, double-buffers one
// stereo pair and serialises it as standard I2S: 64 bclk per frame, 32-bit slots, MSB one
// bclk after the lrclk edge. One frame is 512 clk (bclk = clk/8).
//
// Optional feature: define I2S_TX_ROUND_EN to round half up before the shift; otherwise
// the shift truncates toward minus infinity.
//
// Ports:
//   clk, reset_n     system clock (49.152 MHz), synchronous active-low reset
//   run              0 holds everything idle and cleared, 1 transmits
//   din_valid        one-clk strobe qualifying l_data_in / r_data_in
//   l/r_data_in      34-bit signed interpolated sums
//   i2s_bclk         bit clock, cnt[2]
//   i2s_lrclk        word select, cnt[8] (0 = left, 1 = right)
//   i2s_sdata        serial data, updated when cnt[2:0] == 0
//   underrun         sticky: a frame started without a fresh sample
//   overrun          sticky: a pending sample was overwritten before use
//   test_data        {3'b0, underrun, overrun, fresh, lrclk, cnt[8:0]}

module interp_i2s_tx #(
  parameter int SHIFT            = 8,
  parameter int MUTE_ON_UNDERRUN = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run,
  input  logic        din_valid,
  input  logic [33:0] l_data_in,
  input  logic [33:0] r_data_in,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata,
  output logic        underrun,
  output logic        overrun,
  output logic [15:0] test_data
);

  localparam logic signed [34:0] ROUND_ADD = 35'sd1 <<< (SHIFT - 1);

  // Sign-extend, optionally round, arithmetic shift, then clamp to signed 24 bits.
  function automatic logic [23:0] scale(input logic [33:0] din);
    logic signed [34:0] x;
    logic signed [34:0] y;
    x = {din[33], din};
`ifdef I2S_TX_ROUND_EN
    x = x + ROUND_ADD;
`endif
    y = x >>> SHIFT;
    if (y[34:23] == {12{y[23]}}) begin
      return y[23:0];
    end else if (y[34]) begin
      return 24'h800000;
    end else begin
      return 24'h7FFFFF;
    end
  endfunction

  logic [8:0]  cnt_q, cnt_d;
  logic        sdata_q, sdata_d;
  logic        fresh_q, fresh_d;
  logic        underrun_q, underrun_d;
  logic        overrun_q, overrun_d;
  logic [23:0] pending_l_q, pending_l_d;
  logic [23:0] pending_r_q, pending_r_d;
  logic [23:0] tx_l_q, tx_l_d;
  logic [23:0] tx_r_q, tx_r_d;
  logic [23:0] last_l_q, last_l_d;
  logic [23:0] last_r_q, last_r_d;

  logic [23:0] scaled_l;
  logic [23:0] scaled_r;
  logic [5:0]  bit_b;
  logic [4:0]  slot_p;
  logic [4:0]  bit_idx;
  logic [23:0] slot_word;

  always_comb begin
    scaled_l    = scale(l_data_in);
    scaled_r    = scale(r_data_in);
    bit_b       = cnt_q[8:3];
    slot_p      = bit_b[4:0];
    bit_idx     = 5'd24 - slot_p;
    slot_word   = bit_b[5] ? tx_r_q : tx_l_q;

    cnt_d       = cnt_q;
    sdata_d     = sdata_q;
    fresh_d     = fresh_q;
    underrun_d  = underrun_q;
    overrun_d   = overrun_q;
    pending_l_d = pending_l_q;
    pending_r_d = pending_r_q;
    tx_l_d      = tx_l_q;
    tx_r_d      = tx_r_q;
    last_l_d    = last_l_q;
    last_r_d    = last_r_q;

    if (!run) begin
      cnt_d       = '0;
      sdata_d     = 1'b0;
      fresh_d     = 1'b0;
      underrun_d  = 1'b0;
      overrun_d   = 1'b0;
      pending_l_d = '0;
      pending_r_d = '0;
      tx_l_d      = '0;
      tx_r_d      = '0;
      last_l_d    = '0;
      last_r_d    = '0;
    end else begin
      cnt_d = cnt_q + 9'd1;

      if (cnt_q == 9'd511) begin
        // Frame boundary: a strobe landing here goes straight to the transmit
        // registers, so it neither overruns nor underruns.
        if (din_valid) begin
          tx_l_d   = scaled_l;
          tx_r_d   = scaled_r;
          last_l_d = scaled_l;
          last_r_d = scaled_r;
          fresh_d  = 1'b0;
        end else if (fresh_q) begin
          tx_l_d   = pending_l_q;
          tx_r_d   = pending_r_q;
          last_l_d = pending_l_q;
          last_r_d = pending_r_q;
          fresh_d  = 1'b0;
        end else begin
          underrun_d = 1'b1;
          tx_l_d     = (MUTE_ON_UNDERRUN != 0) ? 24'h000000 : last_l_q;
          tx_r_d     = (MUTE_ON_UNDERRUN != 0) ? 24'h000000 : last_r_q;
        end
      end else if (din_valid) begin
        pending_l_d = scaled_l;
        pending_r_d = scaled_r;
        fresh_d     = 1'b1;
        if (fresh_q) begin
          overrun_d = 1'b1;
        end
      end

      // Slot position 0 is the one-bclk I2S delay; positions 25..31 are padding.
      if (cnt_q[2:0] == 3'd0) begin
        if ((slot_p >= 5'd1) && (slot_p <= 5'd24)) begin
          sdata_d = slot_word[bit_idx];
        end else begin
          sdata_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      sdata_q     <= 1'b0;
      fresh_q     <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
      pending_l_q <= '0;
      pending_r_q <= '0;
      tx_l_q      <= '0;
      tx_r_q      <= '0;
      last_l_q    <= '0;
      last_r_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      sdata_q     <= sdata_d;
      fresh_q     <= fresh_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
      pending_l_q <= pending_l_d;
      pending_r_q <= pending_r_d;
      tx_l_q      <= tx_l_d;
      tx_r_q      <= tx_r_d;
      last_l_q    <= last_l_d;
      last_r_q    <= last_r_d;
    end
  end

  assign i2s_bclk  = cnt_q[2];
  assign i2s_lrclk = cnt_q[8];
  assign i2s_sdata = sdata_q;
  assign underrun  = underrun_q;
  assign overrun   = overrun_q;
  assign test_data = {3'b000, underrun_q, overrun_q, fresh_q, cnt_q[8], cnt_q};

endmodule

// File: tb/tb_interp_i2s_tx.sv
// tb/tb_interp_i2s_tx.sv - scoreboard bench for interp_i2s_tx (muting and repeating instances)

module tb_interp_i2s_tx;

  logic        clk;
  logic        reset_n;
  logic        run;
  logic        din_valid;
  logic [33:0] l_data_in;
  logic [33:0] r_data_in;

  logic [1:0]  bclk_w, lrclk_w, sdata_w, un_w, ov_w;
  logic [15:0] td0, td1;

  interp_i2s_tx #(.SHIFT(8), .MUTE_ON_UNDERRUN(1)) dut_mute (
    .clk(clk), .reset_n(reset_n), .run(run), .din_valid(din_valid),
    .l_data_in(l_data_in), .r_data_in(r_data_in),
    .i2s_bclk(bclk_w[0]), .i2s_lrclk(lrclk_w[0]), .i2s_sdata(sdata_w[0]),
    .underrun(un_w[0]), .overrun(ov_w[0]), .test_data(td0)
  );

  interp_i2s_tx #(.SHIFT(8), .MUTE_ON_UNDERRUN(0)) dut_rep (
    .clk(clk), .reset_n(reset_n), .run(run), .din_valid(din_valid),
    .l_data_in(l_data_in), .r_data_in(r_data_in),
    .i2s_bclk(bclk_w[1]), .i2s_lrclk(lrclk_w[1]), .i2s_sdata(sdata_w[1]),
    .underrun(un_w[1]), .overrun(ov_w[1]), .test_data(td1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef I2S_TX_ROUND_EN
  localparam logic [23:0] A3_L = 24'h000002;
`else
  localparam logic [23:0] A3_L = 24'h000001;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic push_exp(input logic [23:0] l0, input logic [23:0] r0,
                          input logic [23:0] l1, input logic [23:0] r1);
    exp_q0.push_back({l0, r0});
    exp_q1.push_back({l1, r1});
  endtask

  // Monitor: deserialise each instance on bclk rising edges, one frame = 64 edges.
  int          nb [2];
  logic        prev_b [2];
  logic        perr [2];
  logic [23:0] wl [2];
  logic [23:0] wr [2];
  int          frame_no [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      nb[i] = 0; prev_b[i] = 1'b0; perr[i] = 1'b0; wl[i] = '0; wr[i] = '0; frame_no[i] = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!run) begin
        nb[i] = 0; prev_b[i] = 1'b0; perr[i] = 1'b0;
      end else begin
        if (bclk_w[i] && !prev_b[i]) begin
          int p;
          logic [47:0] e;
          p = nb[i] % 32;
          if (lrclk_w[i] != (nb[i] >= 32)) perr[i] = 1'b1;
          if (p >= 1 && p <= 24) begin
            if (nb[i] < 32) wl[i][24-p] = sdata_w[i];
            else            wr[i][24-p] = sdata_w[i];
          end else if (sdata_w[i]) begin
            perr[i] = 1'b1;
          end
          if (nb[i] == 63) begin
            e = '0;
            if (i == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
            else if (i == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else begin
              n_checks++;
              $display("FAIL frame%0d inst%0d: frame with no expectation", frame_no[i], i);
            end
            check($sformatf("frame%0d_inst%0d {L,R,pad_err}", frame_no[i], i),
                  {15'd0, wl[i], wr[i], perr[i]}, {15'd0, e, 1'b0});
            frame_no[i]++;
            nb[i] = 0;
            perr[i] = 1'b0;
          end else begin
            nb[i]++;
          end
        end
        prev_b[i] = bclk_w[i];
      end
    end
  end

  task automatic wait_cnt(input logic [8:0] v);
    int k;
    k = 0;
    @(negedge clk);
    while (td0[8:0] != v && k < 1100) begin
      @(negedge clk);
      k++;
    end
    if (td0[8:0] != v) begin
      n_checks++;
      $display("FAIL wait_cnt: cnt %0d never reached, at %0d", v, td0[8:0]);
    end
  endtask

  task automatic issue(input logic [33:0] l, input logic [33:0] r);
    din_valid = 1'b1;
    l_data_in = l;
    r_data_in = r;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; run = 1'b0; din_valid = 1'b0; l_data_in = '0; r_data_in = '0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_state", {bclk_w, lrclk_w, sdata_w, un_w, ov_w, td0, td1},
          {10'd0, 16'd0, 16'd0});

    // F0: cleared transmit registers
    run = 1'b1;
    push_exp(24'h0, 24'h0, 24'h0, 24'h0);
    wait_cnt(9'd100);
    issue(34'h0_1234_5600, 34'h3_FFFF_FF00);
    push_exp(24'h123456, 24'hFFFFFF, 24'h123456, 24'hFFFFFF);

    // F1: transmit A1, strobe saturating pair
    wait_cnt(9'd0);
    wait_cnt(9'd50);
    issue(34'h0_8000_0000, 34'h3_0000_0000);
    push_exp(24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000);
    wait_cnt(9'd264);
    check("right_slot_delay_bit", {63'd0, sdata_w[0]}, 64'd0);
    wait_cnt(9'd265);
    check("right_msb_after_264", {62'd0, sdata_w}, {62'd0, 2'b11});
    wait_cnt(9'd400);
    check("no_flags_f1", {60'd0, un_w, ov_w}, 64'd0);

    // F2: left MSB position, strobe small/near-full-scale pair
    wait_cnt(9'd0);
    wait_cnt(9'd8);
    check("left_slot_delay_bit", {62'd0, sdata_w}, 64'd0);
    wait_cnt(9'd16);
    check("left_msb_7fffff", {62'd0, sdata_w}, 64'd0);
    wait_cnt(9'd17);
    check("left_bit22_7fffff", {62'd0, sdata_w}, {62'd0, 2'b11});
    wait_cnt(9'd60);
    issue(34'h0_0000_0180, 34'h0_7FFF_FF80);
    push_exp(A3_L, 24'h7FFFFF, A3_L, 24'h7FFFFF);

    // F3: no strobe -> F4 underruns
    wait_cnt(9'd0);
    wait_cnt(9'd5);
    check("no_underrun_f3", {62'd0, un_w}, 64'd0);
    push_exp(24'h0, 24'h0, A3_L, 24'h7FFFFF);

    // F4: underrun flag, then two strobes -> overrun, B sent in F5
    wait_cnt(9'd0);
    wait_cnt(9'd5);
    check("underrun_set", {60'd0, un_w, ov_w}, {60'd0, 2'b11, 2'b00});
    wait_cnt(9'd100);
    issue(34'h0_0000_1100, 34'h0_0000_2200);
    wait_cnt(9'd300);
    issue(34'h0_00AB_CD00, 34'h3_FFFF_0000);
    push_exp(24'h00ABCD, 24'hFFFF00, 24'h00ABCD, 24'hFFFF00);
    wait_cnt(9'd305);
    check("overrun_set", {62'd0, ov_w}, {62'd0, 2'b11});

    // F5 sends B; F6 aborted at cnt=200
    wait_cnt(9'd0);
    wait_cnt(9'd0);
    wait_cnt(9'd200);
    run = 1'b0;
    @(negedge clk);
    check("abort_cleared", {bclk_w, lrclk_w, sdata_w, un_w, ov_w, td0, td1},
          {10'd0, 16'd0, 16'd0});
    repeat (3) @(negedge clk);

    // G0: restart, cleared regs; strobe exactly at cnt=511 bypasses
    run = 1'b1;
    push_exp(24'h0, 24'h0, 24'h0, 24'h0);
    wait_cnt(9'd511);
    issue(34'h0_0765_4300, 34'h0_0000_0100);
    push_exp(24'h076543, 24'h000001, 24'h076543, 24'h000001);
    wait_cnt(9'd5);
    check("bypass_no_flags", {60'd0, un_w, ov_w}, 64'd0);
    push_exp(24'h0, 24'h0, 24'h076543, 24'h000001);

    // G2: underrun again after bypass frame
    wait_cnt(9'd0);
    wait_cnt(9'd5);
    check("underrun_after_restart", {60'd0, un_w, ov_w}, {60'd0, 2'b11, 2'b00});
    wait_cnt(9'd0);
    repeat (4) @(negedge clk);
    check("scoreboard_drained", {32'(exp_q0.size()), 32'(exp_q1.size())}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
